// File: rtl/bram_pkg.sv
// Shared constants and state encoding for the 512x64 block RAM front-end.
package bram_pkg;
    localparam int RAM_DEPTH_LOG2 = 9;
    localparam int RAM_WIDTH      = 64;
    localparam int RAM_SEL_W      = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/bram_wb_ctrl_if.sv
// Pipelined Wishbone B4 bus bundle between the bus master and the RAM front-end.
interface bram_wb_ctrl_if #(
    parameter int ADR_W = 29
);
    import bram_pkg::*;

    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [RAM_SEL_W-1:0] sel;
    logic [ADR_W-1:0]     adr;
    logic [RAM_WIDTH-1:0] dat_w;
    logic [RAM_WIDTH-1:0] dat_r;
    logic                 ack;
    logic                 stall;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, stall);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, stall);
endinterface

// File: rtl/bram_clear_seq.sv
// Address sequencer for the post-reset zero-fill of the RAM array.
module bram_clear_seq #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [DEPTH_LOG2-1:0] cnt,
    output logic                  done,
    output logic                  busy
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Last address of the sweep; the FSM leaves CLEAR on this edge.
    assign done = en & (cnt == {DEPTH_LOG2{1'b1}});
    assign busy = en;
endmodule

// File: rtl/bram_wb_ctrl.sv
// Wishbone slave driving a 512x64 block RAM with single-cycle accesses and
// acks aligned to the RAM's one-cycle read latency; optional zero-fill after reset.
module bram_wb_ctrl
    import bram_pkg::*;
#(
    parameter int ADR_W          = 29,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int DEPTH_LOG2     = RAM_DEPTH_LOG2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    bram_wb_ctrl_if.slave         wb,
    output logic                  ram_en,
    output logic [RAM_SEL_W-1:0]  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_a,
    output logic [RAM_WIDTH-1:0]  ram_di,
    input  logic [RAM_WIDTH-1:0]  ram_do,
    output logic                  clear_busy
);
    state_t                state;
    state_t                state_nxt;
    logic [DEPTH_LOG2-1:0] clr_cnt;
    logic                  clr_done;
    logic                  accept;
    logic                  stall;
    logic                  ack_q;
    logic                  rd_q;

    bram_clear_seq #(.DEPTH_LOG2(DEPTH_LOG2)) u_clear_seq (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (state == CLEAR),
        .cnt   (clr_cnt),
        .done  (clr_done),
        .busy  (clear_busy)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_done) begin
            state_nxt = RUN;
        end
    end

    // RAM is never written while reset is held, whichever path owns it.
    always_comb begin
        accept = 1'b0;
        stall  = 1'b0;
        ram_en = 1'b0;
        ram_we = '0;
        ram_a  = wb.adr[DEPTH_LOG2-1:0];
        ram_di = wb.dat_w;
        case (state)
            CLEAR: begin
                stall  = 1'b1;
                ram_a  = clr_cnt;
                ram_di = '0;
                ram_en = RST_N;
                ram_we = {RAM_SEL_W{RST_N}};
            end
            RUN: begin
                accept = wb.cyc & wb.stb & RST_N;
                ram_en = accept;
                ram_we = (accept & wb.we) ? wb.sel : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ack_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            ack_q <= accept;
            rd_q  <= accept & ~wb.we;
        end
    end

    // Dropping cyc kills an in-flight ack; read data comes straight off the RAM output register.
    assign wb.ack   = ack_q & wb.cyc;
    assign wb.dat_r = rd_q ? ram_do : '0;
    assign wb.stall = stall;
endmodule

// File: tb/tb_bram_wb_ctrl.sv
// Directed bench for bram_wb_ctrl with a behavioural 512x64 byte-write RAM.
module tb_bram_wb_ctrl;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [8:0]  ram_a;
    logic [63:0] ram_di;
    logic [63:0] ram_do;
    logic        clear_busy;
    logic [63:0] mem [512];

    int n_cmp = 0;
    int n_bad = 0;

    bram_wb_ctrl_if #(.ADR_W(29)) wb ();

    bram_wb_ctrl #(.ADR_W(29), .CLEAR_ON_RESET(1'b1), .DEPTH_LOG2(9)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wb         (wb),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_a      (ram_a),
        .ram_di     (ram_di),
        .ram_do     (ram_do),
        .clear_busy (clear_busy)
    );

    always #5 CLK = ~CLK;

    // Registered-output RAM; a write at edge N is visible to a read sampled at N+1.
    always @(posedge CLK) begin
        if (ram_en) begin
            for (int i = 0; i < 8; i++)
                if (ram_we[i]) mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
            ram_do <= mem[ram_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic cyc, input logic stb, input logic we, input logic [7:0] sel,
                       input logic [28:0] adr, input logic [63:0] dat);
        wb.cyc   = cyc;
        wb.stb   = stb;
        wb.we    = we;
        wb.sel   = sel;
        wb.adr   = adr;
        wb.dat_w = dat;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 8'h00, 29'h0, 64'h0);
    endtask

    // Steps through the zero-fill with read requests pending; they must be ignored.
    task automatic check_clear(input string tag);
        int n   = 0;
        int bad = 0;
        drv(1'b1, 1'b1, 1'b0, 8'hFF, 29'h1A5, 64'h0);
        chk({tag, "_first_a"}, 64'(ram_a), 64'h0);
        while (clear_busy && n < 600) begin
            if (ram_a != 9'(n) || ram_we != 8'hFF || !ram_en || ram_di != 64'h0 ||
                !wb.stall || wb.ack) bad++;
            step();
            n++;
        end
        idle();
        chk({tag, "_len"}, 64'(n), 64'd512);
        chk({tag, "_pattern_errs"}, 64'(bad), 64'd0);
        chk({tag, "_stall_after"}, 64'(wb.stall), 64'h0);
    endtask

    task automatic rd_req(input logic [28:0] adr);
        drv(1'b1, 1'b1, 1'b0, 8'h00, adr, 64'h0);
    endtask

    task automatic wr_req(input logic [28:0] adr, input logic [7:0] sel, input logic [63:0] dat);
        drv(1'b1, 1'b1, 1'b1, sel, adr, dat);
    endtask

    initial begin
        RST_N = 1'b0;
        wr_req(29'h5, 8'hFF, 64'hDEAD);
        step();
        step();
        chk("rst_ack", 64'(wb.ack), 64'h0);
        chk("rst_dat_r", wb.dat_r, 64'h0);
        chk("rst_stall", 64'(wb.stall), 64'h1);
        chk("rst_busy", 64'(clear_busy), 64'h1);
        chk("rst_ram_en", 64'(ram_en), 64'h0);
        chk("rst_ram_we", 64'(ram_we), 64'h0);

        RST_N = 1'b1;
        check_clear("clear");

        rd_req(29'h1A5);
        step();
        chk("rd1a5_ack", 64'(wb.ack), 64'h1);
        chk("rd1a5_dat", wb.dat_r, 64'h0);
        idle();
        step();
        chk("idle_ack", 64'(wb.ack), 64'h0);

        wr_req(29'h3, 8'hFF, 64'h0123456789ABCDEF);
        chk("wr_ram_a", 64'(ram_a), 64'h3);
        chk("wr_ram_we", 64'(ram_we), 64'hFF);
        step();
        chk("wr3_ack", 64'(wb.ack), 64'h1);
        rd_req(29'h3);
        chk("rd_ram_we", 64'(ram_we), 64'h0);
        step();
        chk("rd3_ack", 64'(wb.ack), 64'h1);
        chk("rd3_dat", wb.dat_r, 64'h0123456789ABCDEF);

        wr_req(29'h3, 8'h0F, 64'hFFFFFFFF_00000000);
        step();
        chk("pwr_ack", 64'(wb.ack), 64'h1);
        wr_req(29'h3, 8'h00, 64'hFFFFFFFF_FFFFFFFF);
        chk("sel0_ram_we", 64'(ram_we), 64'h0);
        chk("sel0_ram_en", 64'(ram_en), 64'h1);
        step();
        chk("sel0_ack", 64'(wb.ack), 64'h1);
        rd_req(29'h3);
        step();
        chk("prd_dat", wb.dat_r, 64'h01234567_00000000);

        for (int i = 0; i < 4; i++) begin
            wr_req(29'(i), 8'hFF, 64'h10 + 64'(i));
            step();
            chk("pre_ack", 64'(wb.ack), 64'h1);
        end
        rd_req(29'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("b2b_ack", 64'(wb.ack), 64'h1);
            chk("b2b_dat", wb.dat_r, 64'h10 + 64'(i - 1));
            chk("b2b_stall", 64'(wb.stall), 64'h0);
            if (i < 4) rd_req(29'(i));
            else idle();
        end
        step();
        chk("b2b_end_ack", 64'(wb.ack), 64'h0);

        rd_req(29'h1);
        step();
        idle();
        chk("abort_ack", 64'(wb.ack), 64'h0);
        step();
        chk("abort_ack_next", 64'(wb.ack), 64'h0);
        rd_req(29'h200);
        chk("alias_ram_a", 64'(ram_a), 64'h0);
        step();
        chk("alias_ack", 64'(wb.ack), 64'h1);
        chk("alias_dat", wb.dat_r, 64'h10);
        idle();

        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        rd_req(29'h7);
        for (int i = 0; i < 300; i++) begin
            if (wb.ack) chk("midclr_pre_ack", 64'(wb.ack), 64'h0);
            step();
        end
        chk("midclr_a300", 64'(ram_a), 64'd300);
        RST_N = 1'b0;
        #1;
        chk("midclr_rst_we", 64'(ram_we), 64'h0);
        step();
        RST_N = 1'b1;
        check_clear("reclear");

        rd_req(29'h3);
        step();
        chk("zero3_ack", 64'(wb.ack), 64'h1);
        chk("zero3_dat", wb.dat_r, 64'h0);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_wb_ctrl.md
Name: bram_wb_ctrl

Overview:
Wishbone slave front-end that sits directly upstream of the 512x64 block RAM and drives its CLK-domain port: WE[7:0], EN, Di, A, and it consumes Do. It converts pipelined Wishbone B4 cycles from the Microwatt core or bus into single-cycle RAM accesses, and it generates registered acks that line up with the RAM's one-cycle read latency. It can optionally zero the whole array after reset before it accepts bus traffic.

Parameters:
ADR_W, 29, width of wb_adr (doubleword address); only bits [8:0] index the RAM, upper bits ignored (aliasing).
CLEAR_ON_RESET, 1, 1 = run 512-cycle zero-fill after reset; 0 = go straight to RUN.
DEPTH_LOG2, 9, RAM index width; fixed at 9 for RAM_512x64, kept as a parameter for the shared package.

Ports:
CLK  in  1  system clock; all state changes on rising edge.
RST_N  in  1  synchronous, active-low reset.
wb_cyc  in  1  bus cycle valid.
wb_stb  in  1  request strobe.
wb_we  in  1  1 = write, 0 = read.
wb_sel  in  8  byte enables; bit i = bits [8i+7:8i].
wb_adr  in  ADR_W  doubleword address.
wb_dat_w  in  64  write data.
wb_dat_r  out  64  read data; valid when wb_ack is high for a read.
wb_ack  out  1  one pulse per accepted request.
wb_stall  out  1  1 = request not accepted this cycle.
ram_en  out  1  to RAM EN.
ram_we  out  8  to RAM WE.
ram_a  out  9  to RAM A.
ram_di  out  64  to RAM Di.
ram_do  in  64  from RAM Do (registered inside RAM, one-cycle latency).
clear_busy  out  1  high while zero-fill in progress.

Behaviour:
- States: CLEAR, RUN. Reset (RST_N=0 at an edge) → CLEAR if CLEAR_ON_RESET=1, else RUN. Clear counter goes to 0, ack_q goes to 0, rd_q goes to 0.
- Output reset values: wb_ack=0, wb_dat_r=0, wb_stall=1 if CLEAR_ON_RESET else 0, clear_busy=CLEAR_ON_RESET, ram_en=0, ram_we=0.
- CLEAR: ram_en=1, ram_we=8'hFF, ram_di=0, ram_a=cnt. cnt increments every cycle. On cnt==511, the next state is RUN and clear_busy drops on the same edge. Total duration is exactly 512 cycles after reset release. wb_stall=1 and wb_ack=0 throughout. Bus requests are ignored, not queued.
- Reset mid-clear: the counter restarts at 0 and the full 512 cycles repeat.
- RUN: wb_stall=0 always, giving one request per cycle. accept = wb_cyc & wb_stb.
- Accept drives the RAM combinationally in the same cycle: ram_en=1, ram_a=wb_adr[8:0], ram_di=wb_dat_w, ram_we = wb_we ? wb_sel : 8'h00.
- No accept: ram_en=0 and ram_we=0.
- Ack pipeline: ack_q <= accept, rd_q <= accept & ~wb_we. wb_ack = ack_q & wb_cyc. The latency is 1 cycle for both reads and writes, and back-to-back requests give back-to-back acks.
- wb_dat_r = rd_q ? ram_do : 64'h0. Data is combinational from the RAM output register, with no extra flop.
- A write with wb_sel=0 is a no-op on the array but is still acked.
- Read after write to the same address in consecutive cycles returns the new data. This relies on RAM write-then-read ordering, because the write completes at edge N and the read samples at N+1.
- Bus abort: if wb_cyc falls, any pending ack is suppressed on the following cycle via the &wb_cyc term. A write already issued to the RAM still takes effect.
- Simultaneous reset and request: reset wins, and no RAM write occurs (ram_we=0 or the clear pattern).

Decomposition:
- Shared package bram_pkg: RAM_DEPTH_LOG2=9, RAM_WIDTH=64, RAM_SEL_W=8, and the state encoding (CLEAR=1'b0, RUN=1'b1).
- A single sub-module, bram_clear_seq, holds the counter, done flag and clear_busy. The top level muxes RAM inputs between it and the bus path. The ack pipeline stays inline.

Test Plan:
- Reset release with CLEAR_ON_RESET=1 → clear_busy=1 and wb_stall=1 for exactly 512 cycles. ram_we=FF with ram_a stepping 0..511, then stall=0. Reading adr 0x1A5 afterwards returns 0.
- Write adr=0x003, sel=FF, data=0x0123456789ABCDEF, then read adr=0x003 on the next cycle → ack on each following cycle, and read data is 0x0123456789ABCDEF.
- Partial write adr=0x003, sel=0x0F, data=0xFFFFFFFF_00000000 → subsequent read returns 0x01234567_00000000.
- Four back-to-back reads of adr 0..3 (preloaded 0x10..0x13) → four consecutive ack pulses starting 1 cycle after the first strobe, with data 0x10,0x11,0x12,0x13 in order, and stall never asserted.
- Read accepted, then wb_cyc dropped the next cycle → wb_ack stays 0. The next transaction on adr 0x200 aliases to index 0x000 and is acked normally.
- RST_N low at clear cycle 300 for one cycle → clear restarts at ram_a=0 and lasts a full 512 cycles; no bus ack occurs during this time.
